// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the in_op encodings, RV32I load/store funct3 codes, the FSM state
// encoding, and the compile-time switch for misaligned-access exceptions.
// Build option: define LSU_MISALIGN_EXC_EN to turn misaligned halfword/word
// accesses into a bus_err pulse instead of silently aligning them.
package mem_lsu_pkg;

  localparam logic [1:0] OP_PASS     = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_STORE    = 2'b10;
  localparam logic [1:0] OP_PASS_ALT = 2'b11;

  localparam logic [2:0] FUNC3_L_B  = 3'b000;
  localparam logic [2:0] FUNC3_L_H  = 3'b001;
  localparam logic [2:0] FUNC3_L_W  = 3'b010;
  localparam logic [2:0] FUNC3_L_BU = 3'b100;
  localparam logic [2:0] FUNC3_L_HU = 3'b101;

  localparam logic [2:0] FUNC3_S_B  = 3'b000;
  localparam logic [2:0] FUNC3_S_H  = 3'b001;
  localparam logic [2:0] FUNC3_S_W  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_t;

`ifdef LSU_MISALIGN_EXC_EN
  localparam bit MISALIGN_EXC_EN = 1'b1;
`else
  localparam bit MISALIGN_EXC_EN = 1'b0;
`endif

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == FUNC3_L_B) || (f3 == FUNC3_L_H) || (f3 == FUNC3_L_W) ||
           (f3 == FUNC3_L_BU) || (f3 == FUNC3_L_HU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == FUNC3_S_B) || (f3 == FUNC3_S_H) || (f3 == FUNC3_S_W);
  endfunction

  // funct3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data alignment.
// Ports: funct3 (load width code), addr_lo (byte offset in word),
//        rdata (raw bus word), data (aligned, sign/zero-extended result).
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      FUNC3_L_B:  data = {{24{byte_v[7]}}, byte_v};
      FUNC3_L_BU: data = {24'h000000, byte_v};
      FUNC3_L_H:  data = {{16{half_v[15]}}, half_v};
      FUNC3_L_HU: data = {16'h0000, half_v};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between execute and writeback.
// Accepts one result per transaction; pass-through results are written back
// after one cycle, loads/stores issue a single bus request and wait for ack
// (bounded by ACK_TIMEOUT cycles).
// Ports: clk, rst (async active-low); in_* execute-stage handshake and fields;
//        flush; bus_* memory bus; wb_* registered writeback; bus_err pulse.
// Build option: LSU_MISALIGN_EXC_EN (see mem_lsu_pkg).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_sdata,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_waddr,
  input  logic        in_we,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        bus_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  lsu_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    hold_f3;
  logic [1:0]    hold_lo;
  logic [4:0]    hold_waddr;
  logic          hold_we;
  logic          hold_load;
  logic [31:0]   load_data;

  logic          accept, is_load, is_store, pass_ok, mem_op, exc, issue, timeout;
  logic [1:0]    eff_lo;
  logic [3:0]    st_sel;
  logic [31:0]   st_data;

  // Output process of the FSM
  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    pass_ok  = 1'b0;
    unique case (in_op)
      OP_LOAD:              is_load  = load_f3_ok(in_funct3);
      OP_STORE:             is_store = store_f3_ok(in_funct3);
      OP_PASS, OP_PASS_ALT: pass_ok  = 1'b1;
    endcase
  end

  assign mem_op  = is_load || is_store;
  assign exc     = MISALIGN_EXC_EN && is_misaligned(in_funct3, in_addr[1:0]);
  assign issue   = accept && mem_op && !exc;
  assign timeout = (cnt == CW'(ACK_TIMEOUT - 1));

  // Misaligned halfwords/words are silently pulled down to their natural boundary.
  always_comb begin
    case (in_funct3[1:0])
      2'b01:   eff_lo = {in_addr[1], 1'b0};
      2'b10:   eff_lo = 2'b00;
      default: eff_lo = in_addr[1:0];
    endcase
  end

  always_comb begin
    st_sel  = 4'b1111;
    st_data = in_sdata;
    case (in_funct3[1:0])
      2'b00: begin
        st_sel  = 4'b0001 << eff_lo;
        st_data = {4{in_sdata[7:0]}};
      end
      2'b01: begin
        st_sel  = eff_lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{in_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .funct3  (hold_f3),
    .addr_lo (hold_lo),
    .rdata   (bus_rdata),
    .data    (load_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; an ack arriving on the timeout cycle still completes normally.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue) state_nxt = ST_WAIT;
      ST_WAIT: if (bus_ack || timeout) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus, writeback and transaction context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= 4'h0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      wb_we      <= 1'b0;
      wb_waddr   <= 5'h0;
      wb_wdata   <= 32'h0;
      bus_err    <= 1'b0;
      hold_f3    <= 3'h0;
      hold_lo    <= 2'h0;
      hold_waddr <= 5'h0;
      hold_we    <= 1'b0;
      hold_load  <= 1'b0;
    end else begin
      wb_we   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            cnt        <= '0;
            bus_req    <= 1'b1;
            bus_we     <= is_store;
            bus_sel    <= is_store ? st_sel : 4'b1111;
            bus_addr   <= {in_addr[31:2], 2'b00};
            bus_wdata  <= is_store ? st_data : 32'h0;
            hold_f3    <= in_funct3;
            hold_lo    <= eff_lo;
            hold_waddr <= in_waddr;
            hold_we    <= in_we && is_load;
            hold_load  <= is_load;
          end else if (accept && mem_op) begin
            bus_err <= 1'b1;
          end else if (accept) begin
            wb_we    <= in_we && pass_ok;
            wb_waddr <= in_waddr;
            wb_wdata <= in_wdata;
          end
        end
        ST_WAIT: begin
          // A flush lets the bus transfer finish but drops its writeback.
          if (flush) hold_we <= 1'b0;
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (hold_load) begin
              wb_we    <= hold_we && !flush;
              wb_waddr <= hold_waddr;
              wb_wdata <= load_data;
            end
          end else if (timeout) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  localparam int TO = 16;
`ifdef LSU_MISALIGN_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_sdata = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic [4:0]  in_waddr = 5'h0;
  logic        in_we = 1'b0;
  logic        flush = 1'b0;
  logic        bus_req, bus_we, bus_err, wb_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, wb_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [4:0]  wb_waddr;

  mem_lsu #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_sdata(in_sdata), .in_wdata(in_wdata),
    .in_waddr(in_waddr), .in_we(in_we), .flush(flush), .bus_req(bus_req), .bus_we(bus_we),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] sel; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic [4:0] waddr; logic [31:0] wdata; } wb_exp_t;
  typedef struct { int delay; logic [31:0] rdata; } resp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  bit       err_q[$];
  resp_t    resp_q[$];
  int       checks = 0;
  int       failures = 0;

  // Reference: value a load returns, from the RV32I definition.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // Reference: {sel, wdata} for a store.
  function automatic logic [35:0] store_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] sd);
    case (f3)
      3'd0:    return {4'b0001 << a[1:0], {4{sd[7:0]}}};
      3'd1:    return {(a[1] ? 4'b1100 : 4'b0011), {2{sd[15:0]}}};
      default: return {4'b1111, sd};
    endcase
  endfunction

  // Monitor: compares every DUT-presented event with the scoreboard.
  initial begin : monitor
    bus_exp_t cur;
    wb_exp_t  w;
    logic     prev_req;
    prev_req = 1'b0;
    cur = '{addr: 32'h0, we: 1'b0, sel: 4'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        checks++;
        if (bus_q.size() == 0) begin
          failures++;
          $display("FAIL bus_unexpected got addr=%h sel=%b", bus_addr, bus_sel);
        end else begin
          cur = bus_q.pop_front();
          if (bus_addr !== cur.addr || bus_we !== cur.we || bus_sel !== cur.sel ||
              (cur.we && bus_wdata !== cur.wdata)) begin
            failures++;
            $display("FAIL bus_issue got addr=%h we=%b sel=%b wdata=%h want addr=%h we=%b sel=%b wdata=%h",
                     bus_addr, bus_we, bus_sel, bus_wdata, cur.addr, cur.we, cur.sel, cur.wdata);
          end
        end
      end else if (bus_req && prev_req) begin
        checks++;
        if (bus_addr !== cur.addr || bus_we !== cur.we || bus_sel !== cur.sel ||
            (cur.we && bus_wdata !== cur.wdata)) begin
          failures++;
          $display("FAIL bus_hold got addr=%h sel=%b wdata=%h want addr=%h sel=%b wdata=%h",
                   bus_addr, bus_sel, bus_wdata, cur.addr, cur.sel, cur.wdata);
        end
      end
      prev_req = bus_req;
      if (wb_we) begin
        checks++;
        if (wb_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected got waddr=%0d wdata=%h", wb_waddr, wb_wdata);
        end else begin
          w = wb_q.pop_front();
          if (wb_waddr !== w.waddr || wb_wdata !== w.wdata) begin
            failures++;
            $display("FAIL wb_data got waddr=%0d wdata=%h want waddr=%0d wdata=%h",
                     wb_waddr, wb_wdata, w.waddr, w.wdata);
          end
        end
      end
      if (bus_err) begin
        checks++;
        if (err_q.size() == 0) begin
          failures++;
          $display("FAIL err_unexpected got bus_err=1 want 0");
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  // Bus slave: acks after the delay chosen by the stimulus (delay >= TO means never).
  initial begin : responder
    resp_t r;
    int    k;
    bit    busy;
    busy = 1'b0;
    k = 0;
    r = '{delay: 0, rdata: 32'h0};
    forever begin
      @(posedge clk); #1;
      if (bus_ack) begin
        bus_ack = 1'b0;
        busy = 1'b0;
      end else if (bus_req) begin
        if (!busy) begin
          busy = 1'b1;
          k = 0;
          if (resp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_missing got bus_req=1 want no request");
            r = '{delay: 0, rdata: 32'h0};
          end else begin
            r = resp_q.pop_front();
          end
        end else begin
          k++;
        end
        if (k == r.delay) begin
          bus_ack = 1'b1;
          bus_rdata = r.rdata;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < TO + 8) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL ready_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata, wb_we, wb_waddr, wb_wdata, bus_err} !== '0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s got req=%b sel=%b addr=%h wb_we=%b wdata=%h err=%b rdy=%b want all 0 rdy=1",
               name, bus_req, bus_sel, bus_addr, wb_we, wb_wdata, bus_err, in_ready);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] wdata, input logic [4:0] waddr,
                       input logic we, input int delay, input logic [31:0] rdata, input bit fl);
    bit       ld, st, mis, pass_wb;
    int       n, exp_n, pre;
    bus_exp_t b;
    logic [35:0] sm;
    ld  = (op == 2'b01) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st  = (op == 2'b10) && (f3 inside {3'd0, 3'd1, 3'd2});
    mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    pass_wb = !ld && !st && we && (op == 2'b00 || op == 2'b11);
    exp_n = 0;
    if (!ld && !st) begin
      if (pass_wb) wb_q.push_back('{waddr: waddr, wdata: wdata});
    end else if (mis && EXC) begin
      err_q.push_back(1'b1);
    end else begin
      sm = store_model(f3, addr, sdata);
      b.addr  = addr & 32'hFFFF_FFFC;
      b.we    = st;
      b.sel   = st ? sm[35:32] : 4'b1111;
      b.wdata = sm[31:0];
      bus_q.push_back(b);
      resp_q.push_back('{delay: delay, rdata: rdata});
      if (delay >= TO) begin
        err_q.push_back(1'b1);
        exp_n = TO;
      end else begin
        exp_n = delay + 1;
        if (ld && we && !fl) wb_q.push_back('{waddr: waddr, wdata: load_model(f3, addr, rdata)});
      end
    end
    wait_ready(n);
    in_op = op; in_funct3 = f3; in_addr = addr; in_sdata = sdata;
    in_wdata = wdata; in_waddr = waddr; in_we = we; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_addr = $urandom; in_wdata = $urandom; in_sdata = $urandom;
    if (pass_wb) begin
      checks++;
      if (wb_we !== 1'b1 || wb_wdata !== wdata || wb_waddr !== waddr) begin
        failures++;
        $display("FAIL pass_latency got wb_we=%b wdata=%h want wb_we=1 wdata=%h", wb_we, wb_wdata, wdata);
      end
    end
    pre = 0;
    if (fl && (ld || st) && !(mis && EXC)) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      pre = 1;
    end
    wait_ready(n);
    checks++;
    if (n + pre != exp_n) begin
      failures++;
      $display("FAIL op_latency got %0d cycles want %0d", n + pre, exp_n);
    end
  endtask

  task automatic idle_flush(input logic [31:0] wdata, input logic [4:0] waddr);
    int n;
    wait_ready(n);
    in_op = 2'b00; in_wdata = wdata; in_waddr = waddr; in_we = 1'b1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (wb_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_flush got wb_we=%b want 0", wb_we);
    end
  endtask

  task automatic reset_mid_wait();
    int n;
    bus_q.push_back('{addr: 32'h200, we: 1'b0, sel: 4'b1111, wdata: 32'h0});
    resp_q.push_back('{delay: 1000, rdata: 32'h0});
    wait_ready(n);
    in_op = 2'b01; in_funct3 = 3'd2; in_addr = 32'h200; in_we = 1'b1; in_waddr = 5'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset("reset_mid_wait");
    @(posedge clk); #1;
    check_reset("reset_held");
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : driver
    int sel;
    int dly;
    logic [31:0] a;
    #12 check_reset("reset_state");
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    issue(2'b00, 3'd0, 32'h0,   32'h0,        32'h12345678, 5'd5,  1'b1, 0, 32'h0, 1'b0);
    issue(2'b10, 3'd0, 32'h103, 32'h000000AB, 32'h0,        5'd0,  1'b0, 2, 32'h0, 1'b0);
    issue(2'b01, 3'd0, 32'h102, 32'h0,        32'h0,        5'd7,  1'b1, 1, 32'h00800000, 1'b0);
    issue(2'b01, 3'd4, 32'h102, 32'h0,        32'h0,        5'd8,  1'b1, 0, 32'h00800000, 1'b0);
    issue(2'b01, 3'd1, 32'h106, 32'h0,        32'h0,        5'd10, 1'b1, 3, 32'h80017F00, 1'b0);
    issue(2'b10, 3'd1, 32'h102, 32'h1234BEEF, 32'h0,        5'd0,  1'b0, 0, 32'h0, 1'b0);
    issue(2'b10, 3'd2, 32'h100, 32'hCAFEF00D, 32'h0,        5'd0,  1'b0, 4, 32'h0, 1'b0);
    issue(2'b01, 3'd2, 32'h200, 32'h0,        32'h0,        5'd3,  1'b1, TO, 32'h0, 1'b0);
    issue(2'b01, 3'd2, 32'h204, 32'h0,        32'h0,        5'd4,  1'b1, TO - 1, 32'hDEADBEEF, 1'b0);
    issue(2'b01, 3'd2, 32'h101, 32'h0,        32'h0,        5'd6,  1'b1, 1, 32'h11223344, 1'b0);
    issue(2'b01, 3'd0, 32'h300, 32'h0,        32'h0,        5'd11, 1'b1, 2, 32'h000000FF, 1'b1);
    idle_flush(32'h55AA55AA, 5'd12);
    issue(2'b01, 3'd3, 32'h400, 32'h0,        32'h77777777, 5'd13, 1'b1, 0, 32'h0, 1'b0);
    issue(2'b10, 3'd5, 32'h400, 32'h0,        32'h66666666, 5'd14, 1'b1, 0, 32'h0, 1'b0);
    issue(2'b11, 3'd0, 32'h0,   32'h0,        32'h0BADF00D, 5'd15, 1'b1, 0, 32'h0, 1'b0);
    reset_mid_wait();

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       dly = $urandom_range(0, 4);
      else if (sel == 7) dly = TO - 1;
      else if (sel == 8) dly = TO;
      else               dly = TO + 2;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = 32'h100 + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) idle_flush($urandom, 5'($urandom));
      issue(2'($urandom), 3'($urandom), a, $urandom, $urandom, 5'($urandom),
            1'($urandom), dly, $urandom, $urandom_range(0, 7) == 0);
    end

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (wb_q.size() != 0) begin
      failures++;
      $display("FAIL wb_missing got %0d pending want 0", wb_q.size());
    end
    checks++;
    if (bus_q.size() != 0) begin
      failures++;
      $display("FAIL bus_missing got %0d pending want 0", bus_q.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      failures++;
      $display("FAIL err_missing got %0d pending want 0", err_q.size());
    end
    checks++;
    if (resp_q.size() != 0) begin
      failures++;
      $display("FAIL resp_unused got %0d pending want 0", resp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, the maximum number of WAIT cycles without bus_ack before an abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, the execute stage presents an instruction result.
REQ-005 SHALL have port in_ready, output, 1, the LSU accepts the presented result this cycle.
REQ-006 SHALL have port in_op, input, 2, operation: 00 pass-through, 01 load, 10 store, 11 treated as pass-through.
REQ-007 SHALL have port in_funct3, input, 3, RV32I load/store width code.
REQ-008 SHALL have port in_addr, input, 32, effective address (rs1+imm).
REQ-009 SHALL have port in_sdata, input, 32, store source register value.
REQ-010 SHALL have port in_wdata, input, 32, ALU result for pass-through.
REQ-011 SHALL have port in_waddr, input, 5, destination register.
REQ-012 SHALL have port in_we, input, 1, destination write enable.
REQ-013 SHALL have port flush, input, 1, discard the in-flight result.
REQ-014 SHALL have bus ports: bus_req (output, 1), bus_we (output, 1), bus_sel (output, 4), bus_addr (output, 32, word-aligned), bus_wdata (output, 32), bus_rdata (input, 32) and bus_ack (input, 1).
REQ-015 SHALL have ports wb_we (output, 1), wb_waddr (output, 5) and wb_wdata (output, 32), all registered writeback.
REQ-016 SHALL have port bus_err, output, 1, a one-cycle pulse on timeout or misalignment.

Function
REQ-017 SHALL implement states IDLE and WAIT; in_ready=1 only in IDLE.
REQ-018 In IDLE, an accepted pass-through SHALL drive wb_we=in_we, wb_waddr=in_waddr and wb_wdata=in_wdata on the next edge (latency 1); when nothing is accepted, wb_we=0.
REQ-019 An accepted load or store in IDLE SHALL register bus_req=1, bus_addr={in_addr[31:2],2'b00}, bus_we (store only), bus_sel and bus_wdata, then enter WAIT.
REQ-020 Store lanes SHALL be: SB sel=1<<addr[1:0] with data {4{b}}; SH sel=0011 or 1100 with data {2{h}}; SW sel=1111.
REQ-021 Load bus_sel SHALL be 1111; the byte/half SHALL be selected from bus_rdata by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-022 bus_req and all bus_* outputs SHALL be held stable in WAIT until bus_ack.
REQ-023 On bus_ack in WAIT, the next edge SHALL deassert bus_req, write the load result (wb_we=in_we) or wb_we=0 for a store, and return to IDLE; the latency is 1 + ack cycles + 1.
REQ-024 The WAIT counter SHALL count cycles; at ACK_TIMEOUT without ack, the LSU SHALL drop bus_req, pulse bus_err, keep wb_we=0 and go to IDLE; ack in the same cycle as timeout wins.
REQ-025 flush in IDLE SHALL block acceptance; flush in WAIT SHALL NOT abort the bus transfer but SHALL suppress the writeback at completion.
REQ-026 An invalid funct3 SHALL be treated as pass-through with wb_we=0.

Reset
REQ-027 While rst=0: state=IDLE, counter=0, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, wb_we=0, wb_waddr=0, wb_wdata=0, bus_err=0, immediately, including mid-WAIT.

Configuration
REQ-028 With LSU_MISALIGN_EXC_EN defined, a misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) access SHALL issue no bus request, pulse bus_err next cycle and keep wb_we=0.
REQ-029 Without LSU_MISALIGN_EXC_EN, misaligned accesses SHALL proceed with low address bits forced to 0 for SH/LH (bit 0) and SW/LW (bits 1:0), and bus_err SHALL only indicate timeout.

Structure
REQ-030 The shared defines package SHALL hold the in_op encodings, FUNC3_L_*/FUNC3_S_* codes, state encodings and the LSU_MISALIGN_EXC_EN guard.
REQ-031 Load extraction/extension SHALL be a combinational sub-module lsu_load_align.

Verification
REQ-032 Pass-through: in_wdata=32'h12345678, in_waddr=5 -> wb_we=1, wb_wdata=32'h12345678 one cycle later.
REQ-033 SB at addr 0x103, data 0xAB -> bus_addr=0x100, bus_sel=1000, bus_wdata=32'hABABABAB; ack after 3 cycles -> IDLE, wb_we=0.
REQ-034 LB at addr 0x102, bus_rdata=32'h00800000 -> wb_wdata=32'hFFFFFF80; LBU -> 32'h00000080.
REQ-035 No ack for 16 cycles -> bus_req drops, bus_err pulses once, in_ready=1 next cycle.
REQ-036 rst low mid-WAIT -> all outputs 0 immediately; flush during load WAIT -> ack completes, wb_we stays 0.
REQ-037 LW at addr 0x101 -> with the macro: no bus_req and a bus_err pulse; without it: bus_addr=0x100.
